seg7_display_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between up to four hardware requesters (e.g. mouse position, IR command, timer, CPU message). Each requester presents a 16-bit hex value and a dot mask. The arbiter grants the display to one requester at a time, with a programmable minimum dwell time, in either round-robin or fixed-priority mode. It is configured by the CPU over the data bus, and its registered output feeds the digit-scan/decoder stage.

---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/seg7_display_arbiter_tick_gen.sv | 35 +++
 rtl/seg7_display_arbiter.sv | 157 +++++++++++++++
 tb/tb_seg7_display_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the seven-segment display arbiter:
//               arbiter state type, bus register offsets, CTRL bit layout and
//               winner-selection helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [7:0] REG_CTRL   = 8'd0;
  localparam logic [7:0] REG_DWELL  = 8'd1;
  localparam logic [7:0] REG_STATUS = 8'd2;

  localparam int         CTRL_EN_BIT   = 0;
  localparam int         CTRL_PRIO_BIT = 1;
  localparam logic [7:0] CTRL_RST      = 8'h01;

  // Round-robin pick: first set bit scanning upward from last+1, wrapping.
  // The loop runs from the farthest offset down so the nearest one wins.
  // Offset 4 lands back on 'last' itself, so it is chosen only if alone.
  function automatic logic [1:0] next_rr(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    next_rr = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) next_rr = idx;
    end
  endfunction

  // Fixed-priority pick: lowest set index.
  function automatic logic [1:0] lowest_idx(input logic [3:0] req);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) lowest_idx = 2'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_display_arbiter_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : seg7_tick_gen
// Description : Free-running divider counting 0..TICK_DIV-1; tick is high for
//               the one cycle in which the counter wraps.
// Ports       : clk_sys, rst (sync, active-high), tick (out, 1-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_sys,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/seg7_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display_arbiter
// Description : Grants the 4-digit display to one of four requesters with a
//               minimum dwell time, round-robin or fixed-priority, configured
//               over the CPU bus. Outputs are registered for the scan stage.
// Ports       : clk_sys, rst (sync, active-high)
//               BUS_DATA/BUS_ADDR/BUS_WE : CPU bus (CTRL, DWELL, STATUS)
//               req_i[3:0], value_i[63:0], dots_i[15:0] : requester inputs
//               grant_o, disp_value, disp_dots, disp_src, disp_valid : display
// Config      : SEG7_ARB_STATUS_EN - when defined, a read of BASE_ADDR+2
//               returns STATUS for one cycle; otherwise BUS_DATA is never
//               driven.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int         TICK_DIV  = 50000,
  parameter logic [7:0] BASE_ADDR = 8'hD2,
  parameter logic [7:0] DWELL_RST = 8'd100
) (
  input  logic        clk_sys,
  input  logic        rst,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  input  logic [3:0]  req_i,
  input  logic [63:0] value_i,
  input  logic [15:0] dots_i,
  output logic [3:0]  grant_o,
  output logic [15:0] disp_value,
  output logic [3:0]  disp_dots,
  output logic [1:0]  disp_src,
  output logic        disp_valid
);

  localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + REG_CTRL;
  localparam logic [7:0] ADDR_DWELL  = BASE_ADDR + REG_DWELL;
  localparam logic [7:0] ADDR_STATUS = BASE_ADDR + REG_STATUS;

  state_t     state;
  logic       ctrl_en;
  logic       ctrl_prio;
  logic [7:0] dwell_reg;
  logic [7:0] dwell_cnt;
  logic [1:0] cur_idx;     // last granted source; survives IDLE as RR pointer
  logic       tick;

  seg7_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .tick    (tick)
  );

  logic [3:0]  cur_mask;
  logic [3:0]  others;
  logic        preempt;
  logic        switch_now;
  logic [3:0]  pool;
  logic [1:0]  winner;
  logic [7:0]  dwell_load;
  logic [15:0] win_value;
  logic [3:0]  win_dots;
  logic [15:0] cur_value;
  logic [3:0]  cur_dots;

  always_comb begin
    cur_mask   = 4'b0001 << cur_idx;
    others     = req_i & ~cur_mask;
    // (cur_mask - 1) selects every index below the current source.
    preempt    = ctrl_prio && ((req_i & (cur_mask - 4'd1)) != 4'd0);
    switch_now = !req_i[cur_idx] || ((dwell_cnt == 8'd0) && (others != 4'd0)) || preempt;
    // In SWITCH the current source is excluded unless nobody else asks.
    pool       = ((state == SWITCH) && (others != 4'd0)) ? others : req_i;
    winner     = ctrl_prio ? lowest_idx(pool) : next_rr(pool, cur_idx);
    dwell_load = (dwell_reg == 8'd0) ? 8'd1 : dwell_reg;
    win_value  = value_i[{winner, 4'b0000} +: 16];
    win_dots   = dots_i[{winner, 2'b00} +: 4];
    cur_value  = value_i[{cur_idx, 4'b0000} +: 16];
    cur_dots   = dots_i[{cur_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ctrl_en    <= CTRL_RST[CTRL_EN_BIT];
      ctrl_prio  <= CTRL_RST[CTRL_PRIO_BIT];
      dwell_reg  <= DWELL_RST;
      dwell_cnt  <= 8'd0;
      cur_idx    <= 2'd0;
      state      <= IDLE;
      grant_o    <= 4'd0;
      disp_value <= 16'd0;
      disp_dots  <= 4'd0;
      disp_src   <= 2'd0;
      disp_valid <= 1'b0;
    end else begin
      if (BUS_WE && (BUS_ADDR == ADDR_CTRL)) begin
        ctrl_en   <= BUS_DATA[CTRL_EN_BIT];
        ctrl_prio <= BUS_DATA[CTRL_PRIO_BIT];
      end
      if (BUS_WE && (BUS_ADDR == ADDR_DWELL)) begin
        dwell_reg <= BUS_DATA;
      end

      if (!ctrl_en || ((state != HOLD) && (req_i == 4'd0))) begin
        state      <= IDLE;
        grant_o    <= 4'd0;
        disp_value <= 16'd0;
        disp_dots  <= 4'd0;
        disp_src   <= 2'd0;
        disp_valid <= 1'b0;
      end else if (state == HOLD) begin
        disp_value <= cur_value;
        disp_dots  <= cur_dots;
        if (switch_now) begin
          state <= SWITCH;
        end else if (dwell_cnt == 8'd0) begin
          dwell_cnt <= dwell_load;
        end else if (tick) begin
          dwell_cnt <= dwell_cnt - 8'd1;
        end
      end else begin
        // IDLE or SWITCH with at least one requester: grant the winner.
        state      <= HOLD;
        cur_idx    <= winner;
        dwell_cnt  <= dwell_load;
        grant_o    <= 4'b0001 << winner;
        disp_value <= win_value;
        disp_dots  <= win_dots;
        disp_src   <= winner;
        disp_valid <= 1'b1;
      end
    end
  end

`ifdef SEG7_ARB_STATUS_EN
  logic [7:0] status_q;
  logic       status_oe;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      status_q  <= 8'd0;
      status_oe <= 1'b0;
    end else begin
      status_q  <= {disp_valid, 1'b0, disp_src, req_i};
      status_oe <= !BUS_WE && (BUS_ADDR == ADDR_STATUS);
    end
  end

  assign BUS_DATA = status_oe ? status_q : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display_arbiter
// Description : Scoreboard bench for seg7_display_arbiter. Stimulus pushes the
//               expected grant sequence (with dwell-gap windows) into a queue;
//               a monitor pops on every grant change and checks live data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display_arbiter;

  localparam int         TD   = 10;
  localparam logic [7:0] BASE = 8'hD2;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  BUS_DATA;
  logic [7:0]  bus_drv = 8'h00;
  logic        bus_oe = 1'b0;
  logic [7:0]  BUS_ADDR = 8'h00;
  logic        BUS_WE = 1'b0;
  logic [3:0]  req_i = 4'd0;
  logic [63:0] value_i = 64'd0;
  logic [15:0] dots_i = 16'd0;
  logic [3:0]  grant_o;
  logic [15:0] disp_value;
  logic [3:0]  disp_dots;
  logic [1:0]  disp_src;
  logic        disp_valid;

  assign BUS_DATA = bus_oe ? bus_drv : 8'hzz;

  always #5 clk_sys = ~clk_sys;

  seg7_display_arbiter #(
    .TICK_DIV  (TD),
    .BASE_ADDR (BASE),
    .DWELL_RST (8'd3)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .BUS_DATA   (BUS_DATA),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WE     (BUS_WE),
    .req_i      (req_i),
    .value_i    (value_i),
    .dots_i     (dots_i),
    .grant_o    (grant_o),
    .disp_value (disp_value),
    .disp_dots  (disp_dots),
    .disp_src   (disp_src),
    .disp_valid (disp_valid)
  );

  typedef struct {
    logic [3:0] grant;
    int         min_gap;   // 0 = no dwell window check
    int         max_gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   model_last = 0;
  logic rand_vals = 1'b0;
  logic mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    tests++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, v, lo, hi, $time);
    end
  endtask

  task automatic check_z(input string name);
    tests++;
    if (!(BUS_DATA === 8'hzz || BUS_DATA === 8'h00)) begin
      fails++;
      $display("FAIL %s: BUS_DATA got %0h, expected high-Z", name, BUS_DATA);
    end
  endtask

  // Values the DUT saw at the last active edge (live data has 1-cycle latency).
  logic [63:0] pv = 64'd0;
  logic [15:0] pd = 16'd0;
  always @(posedge clk_sys) begin
    pv <= value_i;
    pd <= dots_i;
  end

  always @(negedge clk_sys) begin
    if (rand_vals) begin
      value_i = {$urandom, $urandom};
      dots_i  = 16'($urandom);
    end
  end

  // Monitor: pops the scoreboard on every grant change.
  int         cyc = 0;
  int         last_chg = 0;
  logic [3:0] prev_g = 4'd0;
  always @(negedge clk_sys) begin
    cyc++;
    if (mon_on) begin
      if (grant_o !== prev_g) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got %b, expected no change", grant_o);
        end else begin
          e = sb.pop_front();
          check("grant_seq", 32'(grant_o), 32'(e.grant));
          if (e.min_gap > 0) check_range("dwell_gap", cyc - last_chg, e.min_gap, e.max_gap);
        end
        prev_g   = grant_o;
        last_chg = cyc;
      end
      if (disp_valid) begin
        check("live_value", 32'(disp_value), 32'(pv[{disp_src, 4'b0000} +: 16]));
        check("live_dots", 32'(disp_dots), 32'(pd[{disp_src, 2'b00} +: 4]));
        check("grant_onehot", 32'(grant_o), 32'(4'b0001 << disp_src));
      end else begin
        check("blank_grant", 32'(grant_o), 32'd0);
      end
    end
  end

  function automatic int rr_pick(input logic [3:0] mask, input int from);
    for (int s = 1; s <= 4; s++) begin
      if (mask[(from + s) % 4]) return (from + s) % 4;
    end
    return from;
  endfunction

  task automatic expect_grant(input logic [3:0] g, input int lo, input int hi);
    exp_t x;
    x.grant = g; x.min_gap = lo; x.max_gap = hi;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d grant events missing after %0d cycles", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    BUS_ADDR = a; bus_drv = d; bus_oe = 1'b1; BUS_WE = 1'b1;
    @(negedge clk_sys);
    BUS_WE = 1'b0; bus_oe = 1'b0; BUS_ADDR = 8'h00;
  endtask

  // One held request pattern, K expected grants, then release to IDLE.
  task automatic run_round(input logic [3:0] mask, input int k, input int dwell);
    int g;
    int d;
    d = (dwell == 0) ? 1 : dwell;
    g = rr_pick(mask, model_last);
    expect_grant(4'(1 << g), 0, 0);
    if ($countones(mask) > 1) begin
      for (int n = 1; n < k; n++) begin
        g = rr_pick(mask & ~4'(1 << g), g);
        expect_grant(4'(1 << g), (d - 1) * TD + 3, d * TD + 2);
      end
    end
    req_i = mask;
    wait_drain("rr_round", k * (d * TD + 5) + 20);
    model_last = g;
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    wait_drain("rr_release", 10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    check("rst_grant", 32'(grant_o), 32'd0);
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_value", 32'(disp_value), 32'd0);
    check("rst_src", 32'(disp_src), 32'd0);
    check_z("rst_bus_z");
    mon_on = 1'b1;

    // First grant from IDLE, one-cycle latency.
    value_i = {$urandom, $urandom};
    value_i[47:32] = 16'h1234;
    expect_grant(4'b0100, 0, 0);
    req_i = 4'b0100;
    @(negedge clk_sys);
    check("first_src", 32'(disp_src), 32'd2);
    check("first_value", 32'(disp_value), 32'h1234);
    check("first_valid", 32'(disp_valid), 32'd1);
    wait_drain("first_grant", 5);
    model_last = 2;
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    wait_drain("first_release", 10);

    // Round-robin with random request patterns.
    rand_vals = 1'b1;
    bus_write(BASE + 8'd1, 8'd3);
    run_round(4'b1011, 4, 3);
    repeat (6) run_round(4'($urandom_range(1, 15)), $urandom_range(2, 4), 3);

    // Fixed priority: lower index preempts regardless of dwell.
    bus_write(BASE, 8'h03);
    expect_grant(4'b1000, 0, 0);
    req_i = 4'b1000;
    wait_drain("prio_first", 10);
    repeat (4) @(negedge clk_sys);
    expect_grant(4'b0001, 0, 0);
    req_i = 4'b1001;
    @(negedge clk_sys);
    check("prio_switch_old", 32'(grant_o), 32'b1000);
    @(negedge clk_sys);
    check("prio_preempt", 32'(grant_o), 32'b0001);
    wait_drain("prio_preempt_seq", 5);
    model_last = 0;
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    wait_drain("prio_release", 10);
    bus_write(BASE, 8'h01);

    // DWELL=0 acts as one tick; drop of granted request goes straight to IDLE.
    bus_write(BASE + 8'd1, 8'd0);
    expect_grant(4'b0010, 0, 0);
    req_i = 4'b0010;
    wait_drain("dw0_grant", 10);
    model_last = 1;
    repeat (3) @(negedge clk_sys);
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    @(negedge clk_sys);
    check("drop_switch_cycle", 32'(disp_valid), 32'd1);
    @(negedge clk_sys);
    check("drop_idle", 32'(disp_valid), 32'd0);
    wait_drain("drop_seq", 5);
    run_round(4'b0011, 3, 0);
    bus_write(BASE + 8'd1, 8'd3);

    // CTRL disable during HOLD, then reset mid-HOLD.
    expect_grant(4'b0001, 0, 0);
    req_i = 4'b0001;
    wait_drain("en_grant", 10);
    expect_grant(4'd0, 0, 0);
    bus_write(BASE, 8'h00);
    @(negedge clk_sys);
    check("ctrl_disable", 32'(grant_o), 32'd0);
    wait_drain("ctrl_disable_seq", 3);
    expect_grant(4'b0001, 0, 0);
    bus_write(BASE, 8'h01);
    wait_drain("reenable", 10);
    repeat (3) @(negedge clk_sys);
    expect_grant(4'd0, 0, 0);
    rst = 1'b1;
    @(negedge clk_sys);
    check("midrst_grant", 32'(grant_o), 32'd0);
    check("midrst_valid", 32'(disp_valid), 32'd0);
    check("midrst_value", 32'(disp_value), 32'd0);
    check("midrst_dots", 32'(disp_dots), 32'd0);
    check("midrst_src", 32'(disp_src), 32'd0);
    expect_grant(4'b0001, 0, 0);
    rst = 1'b0;
    wait_drain("post_rst", 10);
    model_last = 0;
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    wait_drain("post_rst_release", 10);

    // STATUS read with source 1 granted and req_i=0011.
    expect_grant(4'b0010, 0, 0);
    req_i = 4'b0010;
    wait_drain("status_grant", 10);
    req_i = 4'b0011;
    @(negedge clk_sys);
    BUS_ADDR = BASE + 8'd2;
    BUS_WE = 1'b0;
    @(negedge clk_sys);
`ifdef SEG7_ARB_STATUS_EN
    check("status_read", 32'(BUS_DATA), 32'h93);
`else
    check_z("status_absent");
`endif
    BUS_ADDR = 8'h00;
    @(negedge clk_sys);
    check_z("status_release_z");
    expect_grant(4'd0, 0, 0);
    req_i = 4'd0;
    wait_drain("status_release", 10);

    repeat (3) @(negedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
